sdram_cmd_ctrl: RTL and testbench
=================================

SDRAM_CMD_CTRL -- requirements
Module: sdram_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter INIT_CYCLES, default 20000, meaning power-up wait in clk cycles before the first command.
REQ-002 The block SHALL have parameter REF_INTERVAL, default 780, meaning the maximum number of clk cycles between AUTO REFRESH commands.
REQ-003 The block SHALL have parameter T_RCD, default 2, meaning ACTIVE-to-READ/WRITE spacing in cycles.
REQ-004 The block SHALL have parameter T_RP, default 2, meaning PRECHARGE or auto-precharge recovery in cycles.
REQ-005 The block SHALL have parameter T_RC, default 7, meaning REFRESH-to-next-command spacing in cycles.
REQ-006 The block SHALL have parameter CAS_LAT, default 2, meaning the read CAS latency written into the mode register.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock, shared with the SDRAM pin interface.
REQ-008 The block SHALL have port rst_n, input, 1 bit: the asynchronous, active-low reset.
REQ-009 The block SHALL have port req_valid, input, 1 bit: a user request is present.
REQ-010 The block SHALL have port req_ready, output, 1 bit: the request is accepted this cycle.
REQ-011 The block SHALL have port req_we, input, 1 bit: 1 selects write, 0 selects read.
REQ-012 The block SHALL have port req_addr, input, 24 bits, mapped as {bank[1:0], row[12:0], col[8:0]}.
REQ-013 The block SHALL have port req_wdata, input, 16 bits: the write word.
REQ-014 The block SHALL have port rsp_valid, output, 1 bit: a one-cycle read-data strobe.
REQ-015 The block SHALL have port rsp_rdata, output, 16 bits: the read word.
REQ-016 The block SHALL have port cmd_n, output, 4 bits: {CS_N, RAS_N, CAS_N, WE_N} to the pins.
REQ-017 The block SHALL have port addr_o, output, 15 bits: {bank[1:0], A[12:0]}, driving the interface master modport addr_o.
REQ-018 The block SHALL have port data_o, output, 16 bits: write data to the interface.
REQ-019 The block SHALL have port wr_en_o, output, 1 bit: the data-bus drive enable.
REQ-020 The block SHALL have port data_i, input, 16 bits: registered pin data from the interface.
REQ-021 The block SHALL have port init_done, output, 1 bit: the initialization sequence is complete.

Function
REQ-022 Command encodings SHALL be: NOP=0111, ACTIVE=0011, READ=0101, WRITE=0100, PRECHARGE=0010, REFRESH=0001, LOAD_MODE=0000.
REQ-023 The FSM states SHALL be INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS, IDLE, ACT, RW, RD_WAIT, RECOVER, REFRESH.
REQ-024 Init sequence: NOP for INIT_CYCLES cycles; PRECHARGE with A10=1 (all banks); wait T_RP; REFRESH; wait T_RC; REFRESH; wait T_RC; LOAD_MODE with A=0x020 (burst length 1, sequential, CL=2, burst write); wait 2 cycles; then IDLE with init_done=1.
REQ-025 req_ready SHALL be 1 only in IDLE, with init_done=1 and no refresh pending; a request is accepted when req_valid and req_ready are both 1 in the same cycle.
REQ-026 On accept, the block SHALL latch req_we, req_addr and req_wdata, and issue ACTIVE in that same cycle with addr_o={bank,row}.
REQ-027 After ACTIVE, the block SHALL issue NOP for T_RCD-1 cycles, then READ or WRITE with addr_o={bank, 2'b00, A10=1, 1'b0, col} (auto-precharge).
REQ-028 Write: wr_en_o=1 and data_o=latched wdata only in the WRITE command cycle; wr_en_o=0 in all other cycles.
REQ-029 Read: data_i SHALL be sampled CAS_LAT+1 cycles after the READ command cycle, because the interface adds one register stage.
REQ-030 On that read sample, rsp_rdata SHALL take data_i and rsp_valid SHALL pulse for exactly 1 cycle.
REQ-031 After READ or WRITE, the block SHALL wait in RECOVER until at least T_RP+1 cycles have elapsed, and until read data has been returned for a read, before returning to IDLE.
REQ-032 The refresh counter SHALL count from 0 and set refresh_pending on reaching REF_INTERVAL-1, wrapping to 0.
REQ-033 When IDLE and refresh_pending, the block SHALL issue REFRESH, clear refresh_pending and wait T_RC.
REQ-034 A pending refresh SHALL win over a simultaneous req_valid, and req_ready SHALL be 0 in that cycle.
REQ-035 Refresh that comes due mid-transaction SHALL be deferred until IDLE and never dropped.
REQ-036 The refresh counter SHALL run only after init_done=1.
REQ-037 All wait counters SHALL be down-counters loaded on state entry, with the state exit taken when the count reaches 0.
REQ-038 In every cycle not named above, cmd_n SHALL be NOP.

Reset
REQ-039 While rst_n=0, the block SHALL force state=INIT_WAIT, cmd_n=0111, addr_o=0, data_o=0, wr_en_o=0, req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, all counters=0, and refresh_pending=0.
REQ-040 Reset asserted mid-transaction SHALL abort immediately, with no completing rsp_valid; release SHALL restart the full init sequence.

Verification
REQ-041 Scenario: release reset with INIT_CYCLES=10 -> after 10 NOPs the bench SHALL see PRE(A10=1), REF, REF, MRS(A=0x020) at spec spacing, then init_done=1.
REQ-042 Scenario: write 0xBEEF to addr 0x012345 -> the bench SHALL see ACT with bank=0, row=0x0091, then 2 cycles later WRITE with col=0x145, A10=1, wr_en_o=1 for 1 cycle.
REQ-043 Scenario: read back addr 0x012345 with the bench model returning 0xBEEF -> rsp_valid SHALL pulse once with rsp_rdata=0xBEEF, exactly 3 cycles after READ.
REQ-044 Scenario: req_valid held high in the cycle refresh_pending sets -> the bench SHALL see REFRESH first, req_ready=0, and the request accepted after T_RC.
REQ-045 Scenario: back-to-back requests for 2*REF_INTERVAL cycles -> REFRESH spacing SHALL never exceed REF_INTERVAL plus one transaction length.
REQ-046 Scenario: rst_n dropped 1 cycle after a READ command -> no rsp_valid, all outputs at reset values, and init restarts.

Source files
------------

// File: rtl/sdram_cmd_ctrl.sv
// SDRAM command sequencer: power-up init, single-word auto-precharge reads and
// writes, and periodic auto refresh that is deferred around open transactions.
module sdram_cmd_ctrl #(
  parameter int INIT_CYCLES  = 20000,
  parameter int REF_INTERVAL = 780,
  parameter int T_RCD        = 2,
  parameter int T_RP         = 2,
  parameter int T_RC         = 7,
  parameter int CAS_LAT      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [3:0]  cmd_n,
  output logic [14:0] addr_o,
  output logic [15:0] data_o,
  output logic        wr_en_o,
  input  logic [15:0] data_i,
  output logic        init_done
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  localparam int M1       = (INIT_CYCLES > T_RC) ? INIT_CYCLES : T_RC;
  localparam int M2       = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int M3       = (M2 > CAS_LAT) ? M2 : CAS_LAT;
  localparam int WAIT_MAX = (M1 > M3) ? M1 : M3;
  localparam int CNT_W    = $clog2(WAIT_MAX + 1);
  localparam int REF_W    = (REF_INTERVAL > 2) ? $clog2(REF_INTERVAL) : 1;
  localparam int INIT_LD  = (INIT_CYCLES > 2) ? INIT_CYCLES - 2 : 0;
  // Read data already arrives late enough that extra recovery is rarely needed.
  localparam int RD_REC   = (T_RP > CAS_LAT + 1) ? T_RP - CAS_LAT - 1 : 0;
  localparam logic [12:0] MODE_WORD = 13'((CAS_LAT & 7) << 4);

  typedef enum logic [3:0] {
    INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS,
    IDLE, ACT, RW, RD_WAIT, RECOVER, REFRESH
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              armed_q;
  logic [REF_W-1:0]  ref_cnt_q;
  logic              ref_pend_q;
  logic              we_q;
  logic [1:0]        bank_q;
  logic [8:0]        col_q;
  logic [15:0]       wdata_q;
  logic [3:0]        cmd_q;
  logic [14:0]       addr_q;
  logic [15:0]       data_q;
  logic              wr_en_q;
  logic              rsp_valid_q;
  logic [15:0]       rsp_rdata_q;
  logic              init_done_q;

  assign req_ready = (state_q == IDLE) && init_done_q && !ref_pend_q;
  assign cmd_n     = cmd_q;
  assign addr_o    = addr_q;
  assign data_o    = data_q;
  assign wr_en_o   = wr_en_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign init_done = init_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT_WAIT;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      ref_cnt_q   <= '0;
      ref_pend_q  <= 1'b0;
      we_q        <= 1'b0;
      bank_q      <= '0;
      col_q       <= '0;
      wdata_q     <= '0;
      cmd_q       <= CMD_NOP;
      addr_q      <= '0;
      data_q      <= '0;
      wr_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      cmd_q       <= CMD_NOP;
      data_q      <= '0;
      wr_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);

      case (state_q)
        INIT_WAIT: begin
          // The counter is zero out of reset, so arm it on the first cycle.
          if (!armed_q) begin
            armed_q <= 1'b1;
            cnt_q   <= CNT_W'(INIT_LD);
          end else if (cnt_q == '0) begin
            state_q <= INIT_PRE;
            cmd_q   <= CMD_PRE;
            addr_q  <= 15'h0400;
            cnt_q   <= CNT_W'(T_RP - 1);
          end
        end
        INIT_PRE: if (cnt_q == '0) begin
          state_q <= INIT_REF1;
          cmd_q   <= CMD_REF;
          cnt_q   <= CNT_W'(T_RC - 1);
        end
        INIT_REF1: if (cnt_q == '0) begin
          state_q <= INIT_REF2;
          cmd_q   <= CMD_REF;
          cnt_q   <= CNT_W'(T_RC - 1);
        end
        INIT_REF2: if (cnt_q == '0) begin
          state_q <= INIT_MRS;
          cmd_q   <= CMD_LMR;
          addr_q  <= {2'b00, MODE_WORD};
          cnt_q   <= CNT_W'(1);
        end
        INIT_MRS: if (cnt_q == '0) begin
          state_q     <= IDLE;
          init_done_q <= 1'b1;
        end
        IDLE: begin
          if (ref_pend_q) begin
            state_q    <= REFRESH;
            cmd_q      <= CMD_REF;
            cnt_q      <= CNT_W'(T_RC - 1);
            ref_pend_q <= 1'b0;
          end else if (req_valid && req_ready) begin
            state_q <= ACT;
            cmd_q   <= CMD_ACT;
            addr_q  <= {req_addr[23:22], req_addr[21:9]};
            we_q    <= req_we;
            bank_q  <= req_addr[23:22];
            col_q   <= req_addr[8:0];
            wdata_q <= req_wdata;
            cnt_q   <= CNT_W'(T_RCD - 1);
          end
        end
        ACT: if (cnt_q == '0) begin
          state_q <= RW;
          cmd_q   <= we_q ? CMD_WR : CMD_RD;
          addr_q  <= {bank_q, 2'b00, 1'b1, 1'b0, col_q};
          if (we_q) begin
            wr_en_q <= 1'b1;
            data_q  <= wdata_q;
          end
        end
        RW: begin
          if (we_q) begin
            state_q <= RECOVER;
            cnt_q   <= CNT_W'(T_RP - 1);
          end else begin
            state_q <= RD_WAIT;
            cnt_q   <= CNT_W'(CAS_LAT - 1);
          end
        end
        RD_WAIT: if (cnt_q == '0) begin
          state_q     <= RECOVER;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= data_i;
          cnt_q       <= CNT_W'(RD_REC);
        end
        RECOVER: if (cnt_q == '0) state_q <= IDLE;
        REFRESH: if (cnt_q == '0) state_q <= IDLE;
        default: state_q <= INIT_WAIT;
      endcase

      // Placed after the FSM so a new interval expiring wins over a clear.
      if (init_done_q) begin
        if (ref_cnt_q == REF_W'(REF_INTERVAL - 1)) begin
          ref_cnt_q  <= '0;
          ref_pend_q <= 1'b1;
        end else begin
          ref_cnt_q <= ref_cnt_q + REF_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_cmd_ctrl.sv
// Directed bench for sdram_cmd_ctrl: init sequence, write, read, refresh
// collision, back-to-back refresh spacing and reset abort.
module tb_sdram_cmd_ctrl;

  localparam int INIT_C = 10;
  localparam int REF_I  = 64;
  localparam int TRCD   = 2;
  localparam int TRP    = 2;
  localparam int TRC    = 7;
  localparam int CL     = 2;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] LMR = 4'b0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [23:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [3:0]  cmd_n;
  logic [14:0] addr_o;
  logic [15:0] data_o;
  logic        wr_en_o;
  logic [15:0] data_i = '0;
  logic        init_done;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int ref_n = 0;
  int last_ref = -1;
  int max_gap = 0;
  int rsp_n = 0;
  int act_n = 0;

  sdram_cmd_ctrl #(
    .INIT_CYCLES(INIT_C), .REF_INTERVAL(REF_I), .T_RCD(TRCD),
    .T_RP(TRP), .T_RC(TRC), .CAS_LAT(CL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .cmd_n(cmd_n),
    .addr_o(addr_o), .data_o(data_o), .wr_en_o(wr_en_o), .data_i(data_i),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_ref = -1;
    end else begin
      if (cmd_n == REF && init_done) begin
        if (last_ref >= 0 && cyc - last_ref > max_gap) max_gap = cyc - last_ref;
        last_ref = cyc;
        ref_n++;
      end
      if (rsp_valid) rsp_n++;
      if (cmd_n == ACT) act_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic gap_to_cmd(output int g);
    g = 0;
    do begin
      tick();
      g++;
    end while (cmd_n == NOP && g < 300);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int t_done;
    int snap;
    int snap_act;
    int snap_ref;

    repeat (3) tick();
    chk("rst_cmd",   32'(cmd_n), 32'(NOP));
    chk("rst_addr",  32'(addr_o), 0);
    chk("rst_wdata", 32'({wr_en_o, data_o}), 0);
    chk("rst_hs",    32'({req_ready, rsp_valid, init_done}), 0);
    chk("rst_rdata", 32'(rsp_rdata), 0);

    // init sequence
    rst_n = 1'b1;
    g = 0;
    while (cmd_n == NOP && g < 200) begin
      g++;
      tick();
    end
    chk("init_nops", g, INIT_C);
    chk("init_pre", 32'(cmd_n), 32'(PRE));
    chk("init_pre_a10", 32'(addr_o), 32'h0400);
    gap_to_cmd(g);
    chk("pre_to_ref1", g, TRP);
    chk("ref1_cmd", 32'(cmd_n), 32'(REF));
    gap_to_cmd(g);
    chk("ref1_to_ref2", g, TRC);
    chk("ref2_cmd", 32'(cmd_n), 32'(REF));
    gap_to_cmd(g);
    chk("ref2_to_mrs", g, TRC);
    chk("mrs_cmd", 32'(cmd_n), 32'(LMR));
    chk("mrs_addr", 32'(addr_o), 32'h0020);
    tick();
    chk("init_done_early", 32'(init_done), 0);
    tick();
    chk("init_done", 32'(init_done), 1);
    chk("ready_after_init", 32'(req_ready), 1);
    t_done = cyc;

    // write 0xBEEF to 0x012345
    req_valid = 1'b1; req_we = 1'b1; req_addr = 24'h012345; req_wdata = 16'hBEEF;
    tick();
    req_valid = 1'b0;
    chk("wr_act", 32'(cmd_n), 32'(ACT));
    chk("wr_act_addr", 32'(addr_o), 32'h0091);
    chk("wr_ready_busy", 32'(req_ready), 0);
    tick();
    chk("wr_rcd_nop", 32'({cmd_n, wr_en_o}), 32'({NOP, 1'b0}));
    tick();
    chk("wr_cmd", 32'(cmd_n), 32'(WR));
    chk("wr_addr", 32'(addr_o), 32'h0545);
    chk("wr_en_on", 32'({wr_en_o, data_o}), 32'h1BEEF);
    tick();
    chk("wr_en_off", 32'({cmd_n, wr_en_o, data_o}), 32'({NOP, 1'b0, 16'h0000}));
    tick();
    chk("wr_recover", 32'(req_ready), 0);
    tick();
    chk("wr_idle", 32'(req_ready), 1);

    // read back; bench memory model presents the word once, CL cycles after READ
    snap = rsp_n;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h012345; data_i = 16'hDEAD;
    tick();
    req_valid = 1'b0;
    chk("rd_act_addr", 32'({cmd_n, addr_o}), 32'({ACT, 15'h0091}));
    tick();
    tick();
    chk("rd_cmd", 32'(cmd_n), 32'(RD));
    chk("rd_addr", 32'(addr_o), 32'h0545);
    chk("rd_no_wr_en", 32'(wr_en_o), 0);
    tick();
    chk("rd_rsp_r1", 32'(rsp_valid), 0);
    tick();
    data_i = 16'hBEEF;
    chk("rd_rsp_r2", 32'(rsp_valid), 0);
    tick();
    data_i = 16'hDEAD;
    chk("rd_rsp_r3", 32'(rsp_valid), 1);
    chk("rd_rdata", 32'(rsp_rdata), 32'hBEEF);
    tick();
    chk("rd_rsp_r4", 32'(rsp_valid), 0);
    chk("rd_idle", 32'(req_ready), 1);
    repeat (2) tick();
    chk("rd_one_pulse", rsp_n - snap, 1);

    // refresh collides with a request
    while (cyc < t_done + REF_I - 1) tick();
    chk("ref_pre_ready", 32'(req_ready), 1);
    tick();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 24'hC00001; req_wdata = 16'h1234;
    chk("ref_pend_blocks", 32'(req_ready), 0);
    tick();
    chk("ref_first", 32'(cmd_n), 32'(REF));
    chk("ref_ready_low", 32'(req_ready), 0);
    gap_to_cmd(g);
    req_valid = 1'b0;
    chk("ref_to_act", g, TRC + 1);
    chk("ref_act", 32'({cmd_n, addr_o}), 32'({ACT, 15'h6000}));
    tick();
    tick();
    chk("ref_wr", 32'({cmd_n, addr_o}), 32'({WR, 15'h6401}));
    chk("ref_wr_data", 32'({wr_en_o, data_o}), 32'h11234);

    // back-to-back writes across several refresh intervals
    snap_act = act_n;
    snap_ref = ref_n;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 24'h2ABCDE; req_wdata = 16'h5A5A;
    repeat (2 * REF_I + 30) tick();
    req_valid = 1'b0;
    chk("b2b_ref_gap", 32'(max_gap <= REF_I + 7), 1);
    chk("b2b_ref_count", 32'(ref_n - snap_ref >= 2), 1);
    chk("b2b_progress", 32'(act_n - snap_act >= 20), 1);
    g = 0;
    while (!req_ready && g < 50) begin
      g++;
      tick();
    end
    chk("b2b_drain", 32'(req_ready), 1);

    // reset one cycle after a READ
    snap = rsp_n;
    data_i = 16'hBEEF;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 24'h012345;
    tick();
    req_valid = 1'b0;
    gap_to_cmd(g);
    chk("abort_rd_cmd", 32'(cmd_n), 32'(RD));
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_cmd", 32'(cmd_n), 32'(NOP));
    chk("abort_addr", 32'(addr_o), 0);
    chk("abort_wdata", 32'({wr_en_o, data_o}), 0);
    chk("abort_hs", 32'({req_ready, rsp_valid, init_done}), 0);
    chk("abort_rdata", 32'(rsp_rdata), 0);
    repeat (4) tick();
    rst_n = 1'b1;
    g = 0;
    while (cmd_n == NOP && g < 200) begin
      g++;
      tick();
    end
    chk("reinit_nops", g, INIT_C);
    chk("reinit_pre", 32'({cmd_n, addr_o}), 32'({PRE, 15'h0400}));
    chk("abort_no_rsp", rsp_n - snap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
